// File: rtl/ddr2_req_bridge_if.sv
// Bundle of the core-side DDR2 request port and the controller-side command/response channel.
// master = the bridge, slave = the core plus memory controller environment.
interface ddr2_req_bridge_if #(
    parameter int ADDR_W = 27
);
    logic              ddr2_en;
    logic              ddr2_we;
    logic [31:0]       ddr2_addr;
    logic [31:0]       ddr2_wd;
    logic              ddr2_stall;
    logic [31:0]       ddr2_rd;
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_we;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic [31:0]       mem_cmd_wd;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_rd;

    modport master (
        input  ddr2_en, ddr2_we, ddr2_addr, ddr2_wd,
        output ddr2_stall, ddr2_rd,
        output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wd,
        input  mem_cmd_ready, mem_rsp_valid, mem_rsp_rd
    );

    modport slave (
        output ddr2_en, ddr2_we, ddr2_addr, ddr2_wd,
        input  ddr2_stall, ddr2_rd,
        input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wd,
        output mem_cmd_ready, mem_rsp_valid, mem_rsp_rd
    );
endinterface

// File: rtl/ddr2_req_bridge.sv
// Core DDR2 request port to memory-controller valid/ready bridge with per-transaction timeout.
// Optional feature: define DDR2_BRIDGE_POSTED_WRITE_EN to let writes complete without stalling the core.
module ddr2_req_bridge #(
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = 4096
) (
    input  logic                clock,
    input  logic                resetn,
    ddr2_req_bridge_if.master   bus,
    output logic                err_timeout
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic TO_EN = (TIMEOUT > 0) ? 1'b1 : 1'b0;
    localparam logic [31:0] RD_TIMEOUT = 32'hDEAD_BEEF;

`ifdef DDR2_BRIDGE_POSTED_WRITE_EN
    localparam logic POSTED = 1'b1;
`else
    localparam logic POSTED = 1'b0;
`endif

    state_t            state_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wd_r;
    logic [31:0]       rd_r;
    logic              cmd_valid_r;
    logic              posted_r;
    logic              err_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              expire_s;
    logic              stall_s;

    // Timeout expiry: the TIMEOUT-th cycle spent in CMD/WAIT.
    always_comb begin
        expire_s = 1'b0;
        if (TO_EN && ((state_r == ST_CMD) || (state_r == ST_WAIT))) begin
            expire_s = (cnt_r == CNT_LAST);
        end else begin
            expire_s = 1'b0;
        end
    end

    // Core stall; in IDLE it follows the request so the core sees the hold in the accept cycle.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE:         stall_s = bus.ddr2_en & ~(POSTED & bus.ddr2_we);
            ST_CMD, ST_WAIT: stall_s = 1'b1;
            ST_DONE:         stall_s = 1'b0;
            default:         stall_s = 1'b0;
        endcase
    end

    // Transaction FSM with command latches, read-data hold register and timeout supervision.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wd_r        <= 32'h0000_0000;
            rd_r        <= 32'h0000_0000;
            cmd_valid_r <= 1'b0;
            posted_r    <= 1'b0;
            err_r       <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.ddr2_en) begin
                        we_r        <= bus.ddr2_we;
                        addr_r      <= {bus.ddr2_addr[ADDR_W-3:0], 2'b00};
                        wd_r        <= bus.ddr2_wd;
                        posted_r    <= POSTED & bus.ddr2_we;
                        cnt_r       <= {CNT_W{1'b0}};
                        cmd_valid_r <= 1'b1;
                        state_r     <= ST_CMD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CMD: begin
                    // Expiry beats a coincident ready: the command is abandoned either way.
                    if (expire_s) begin
                        cmd_valid_r <= 1'b0;
                        err_r       <= 1'b1;
                        if (!we_r) begin
                            rd_r <= RD_TIMEOUT;
                        end else begin
                            rd_r <= rd_r;
                        end
                        state_r <= posted_r ? ST_IDLE : ST_DONE;
                    end else if (bus.mem_cmd_ready) begin
                        cmd_valid_r <= 1'b0;
                        cnt_r       <= cnt_r + CNT_W'(1);
                        state_r     <= ST_WAIT;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    // A response in the expiry cycle still completes normally.
                    if (bus.mem_rsp_valid) begin
                        if (!we_r) begin
                            rd_r <= bus.mem_rsp_rd;
                        end else begin
                            rd_r <= rd_r;
                        end
                        state_r <= posted_r ? ST_IDLE : ST_DONE;
                    end else if (expire_s) begin
                        err_r <= 1'b1;
                        if (!we_r) begin
                            rd_r <= RD_TIMEOUT;
                        end else begin
                            rd_r <= rd_r;
                        end
                        state_r <= posted_r ? ST_IDLE : ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ddr2_stall    = stall_s;
    assign bus.ddr2_rd       = rd_r;
    assign bus.mem_cmd_valid = cmd_valid_r;
    assign bus.mem_cmd_we    = we_r;
    assign bus.mem_cmd_addr  = addr_r;
    assign bus.mem_cmd_wd    = wd_r;
    assign err_timeout       = err_r;

endmodule
